vec_pair_scan: RTL and testbench

Parametrised nav × obs vector-pair address generator feeding the matching datapath. It walks every (obs, nav) pair once per run, emitting LANES consecutive nav addresses per beat under a valid/ready handshake. Counters advance only on accepted beats, so backpressure never skips or repeats a pair. Run lengths are set at runtime, a run can be aborted, and the end of each run is reported.

---
 rtl/vec_pair_scan.sv | 188 ++++++++++++++++++
 tb/tb_vec_pair_scan.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/vec_pair_scan.sv
// Nav x obs vector-pair address generator: walks every (obs, nav) pair once per run, LANES nav addresses per beat.
// Optional VEC_PAIR_SCAN_OUTREG_EN: registers all outputs through a 2-entry skid buffer.
module vec_pair_scan #(
  parameter int OBS_VEC_NUM    = 49,
  parameter int NAV_VEC_NUM    = 539,
  parameter int LANES          = 1,
  parameter int NAV_ADDR_WIDTH = $clog2(NAV_VEC_NUM),
  parameter int OBS_ADDR_WIDTH = $clog2(OBS_VEC_NUM)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic [NAV_ADDR_WIDTH:0]   nav_count,
  input  logic [OBS_ADDR_WIDTH:0]   obs_count,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NAV_ADDR_WIDTH-1:0] nav_addr,
  output logic [LANES-1:0]          nav_mask,
  output logic [OBS_ADDR_WIDTH-1:0] obs_addr,
  output logic                      row_first,
  output logic                      row_last,
  output logic                      last,
  output logic                      busy,
  output logic                      done
);

  localparam int NCW = NAV_ADDR_WIDTH + 1;
  localparam int OCW = OBS_ADDR_WIDTH + 1;
  localparam logic [NCW-1:0] NAV_MAX = NCW'(NAV_VEC_NUM);
  localparam logic [OCW-1:0] OBS_MAX = OCW'(OBS_VEC_NUM);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

  typedef struct packed {
    logic [NAV_ADDR_WIDTH-1:0] nav;
    logic [LANES-1:0]          mask;
    logic [OBS_ADDR_WIDTH-1:0] obs;
    logic                      rf;
    logic                      rl;
    logic                      lst;
  } beat_t;

  function automatic logic [NCW-1:0] sat_nav(input logic [NCW-1:0] c);
    return (c > NAV_MAX) ? NAV_MAX : c;
  endfunction

  function automatic logic [OCW-1:0] sat_obs(input logic [OCW-1:0] c);
    return (c > OBS_MAX) ? OBS_MAX : c;
  endfunction

  state_t                    state_q, state_d;
  logic [NAV_ADDR_WIDTH-1:0] nav_q, nav_d;
  logic [OBS_ADDR_WIDTH-1:0] obs_q, obs_d;
  logic [NCW-1:0]            nav_cnt_q, nav_cnt_d;
  logic [OCW-1:0]            obs_cnt_q, obs_cnt_d;

  logic [NCW-1:0] nav_sat, nav_ext, nav_nxt;
  logic [OCW-1:0] obs_sat;
  logic           core_valid, core_ready, core_acc, fin_acc;
  beat_t          beat_c, beat_o, beat_g;
  logic           vld_o;

  assign nav_sat    = sat_nav(nav_count);
  assign obs_sat    = sat_obs(obs_count);
  assign nav_ext    = {1'b0, nav_q};
  assign nav_nxt    = nav_ext + NCW'(LANES);
  assign core_valid = (state_q == S_RUN);
  assign core_acc   = core_valid && core_ready;

  // Stage p0: beat derived from the counter registers
  always_comb begin
    beat_c     = '0;
    beat_c.nav = nav_q;
    beat_c.obs = obs_q;
    for (int i = 0; i < LANES; i++) begin
      beat_c.mask[i] = (nav_ext + NCW'(i)) < nav_cnt_q;
    end
    beat_c.rf  = (nav_q == '0);
    beat_c.rl  = (nav_nxt >= nav_cnt_q);
    beat_c.lst = beat_c.rl && ({1'b0, obs_q} == (obs_cnt_q - OCW'(1)));
  end

  always_comb begin
    state_d   = state_q;
    nav_d     = nav_q;
    obs_d     = obs_q;
    nav_cnt_d = nav_cnt_q;
    obs_cnt_d = obs_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          nav_cnt_d = nav_sat;
          obs_cnt_d = obs_sat;
          nav_d     = '0;
          obs_d     = '0;
          state_d   = (nav_sat == '0 || obs_sat == '0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (core_acc) begin
          if (beat_c.rl) begin
            nav_d = '0;
            obs_d = obs_q + OBS_ADDR_WIDTH'(1);
          end else begin
            nav_d = nav_nxt[NAV_ADDR_WIDTH-1:0];
          end
          if (beat_c.lst) begin
`ifdef VEC_PAIR_SCAN_OUTREG_EN
            state_d = S_DRAIN;
`else
            state_d = S_FIN;
`endif
          end
        end
      end
      // Generation finished; wait for the last buffered beat to leave.
      S_DRAIN: begin
        if (fin_acc) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    nav_q     <= nav_d;
    obs_q     <= obs_d;
    nav_cnt_q <= nav_cnt_d;
    obs_cnt_q <= obs_cnt_d;
  end

`ifdef VEC_PAIR_SCAN_OUTREG_EN
  logic  vld_p0_q, vld_p1_q, adv;
  beat_t beat_p0_q, beat_p1_q;

  // Counters only see the registered skid state, never out_ready.
  assign core_ready = !vld_p0_q;
  assign adv        = !vld_p1_q || out_ready;
  assign fin_acc    = vld_p1_q && out_ready && beat_p1_q.lst;

  // Stage p1: skid entry (p0) and output register (p1)
  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
    end else if (adv) begin
      vld_p1_q <= vld_p0_q || core_acc;
      vld_p0_q <= 1'b0;
    end else if (core_acc) begin
      vld_p0_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (adv) beat_p1_q <= vld_p0_q ? beat_p0_q : beat_c;
    else if (core_acc) beat_p0_q <= beat_c;
  end

  assign vld_o  = vld_p1_q;
  assign beat_o = beat_p1_q;
  assign busy   = (state_q == S_RUN) || (state_q == S_DRAIN);
`else
  assign core_ready = out_ready;
  assign fin_acc    = core_acc && beat_c.lst;
  assign vld_o      = core_valid;
  assign beat_o     = beat_c;
  assign busy       = (state_q == S_RUN);
`endif

  // Payload reads as zero whenever no beat is presented.
  assign beat_g    = vld_o ? beat_o : '0;
  assign out_valid = vld_o;
  assign nav_addr  = beat_g.nav;
  assign nav_mask  = beat_g.mask;
  assign obs_addr  = beat_g.obs;
  assign row_first = beat_g.rf;
  assign row_last  = beat_g.rl;
  assign last      = beat_g.lst;
  assign done      = (state_q == S_FIN);

endmodule

// File: tb/tb_vec_pair_scan.sv
// Randomized bench for vec_pair_scan: LANES=1 and LANES=4 instances against a nested-loop reference model.
module tb_vec_pair_scan;

`ifdef VEC_PAIR_SCAN_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk, rst_n, start, abort, out_ready;
  logic [10:0] nav_count;
  logic [6:0]  obs_count;
  bit          sel;

  logic       v1, rf1, rl1, last1, busy1, done1;
  logic [9:0] nav1;
  logic [0:0] mask1;
  logic [5:0] obs1;
  logic       v4, rf4, rl4, last4, busy4, done4;
  logic [9:0] nav4;
  logic [3:0] mask4;
  logic [5:0] obs4;

  logic        m_valid, m_rf, m_rl, m_last, m_busy, m_done;
  logic [9:0]  m_nav;
  logic [3:0]  m_mask;
  logic [5:0]  m_obs;
  logic [31:0] m_word;

  int n_chk = 0;
  int n_fail = 0;

  vec_pair_scan #(.LANES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .nav_count(nav_count), .obs_count(obs_count),
    .out_valid(v1), .out_ready(out_ready), .nav_addr(nav1), .nav_mask(mask1),
    .obs_addr(obs1), .row_first(rf1), .row_last(rl1), .last(last1),
    .busy(busy1), .done(done1));

  vec_pair_scan #(.LANES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .nav_count(nav_count), .obs_count(obs_count),
    .out_valid(v4), .out_ready(out_ready), .nav_addr(nav4), .nav_mask(mask4),
    .obs_addr(obs4), .row_first(rf4), .row_last(rl4), .last(last4),
    .busy(busy4), .done(done4));

  assign m_valid = sel ? v4    : v1;
  assign m_nav   = sel ? nav4  : nav1;
  assign m_mask  = sel ? mask4 : {3'b000, mask1};
  assign m_obs   = sel ? obs4  : obs1;
  assign m_rf    = sel ? rf4   : rf1;
  assign m_rl    = sel ? rl4   : rl1;
  assign m_last  = sel ? last4 : last1;
  assign m_busy  = sel ? busy4 : busy1;
  assign m_done  = sel ? done4 : done1;
  assign m_word  = {9'd0, m_last, m_rl, m_rf, m_obs, m_mask, m_nav};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (lanes=%0d t=%0t)", tag, got, exp, sel ? 4 : 1, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pack(input int nav, input int msk, input int obs,
                                       input bit rf, input bit rl, input bit lst);
    return {9'd0, lst, rl, rf, 6'(obs), 4'(msk), 10'(nav)};
  endfunction

  task automatic cleanup();
    abort = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    step();
    abort = 1'b0;
  endtask

  // One run: expected beats come from plain nested loops over (obs, nav base).
  task automatic run_scan(input int nc, input int oc, input int stall, input int abort_at, input int poke_at);
    int L, ncc, occ, idx, msk;
    logic [31:0] exp_q[$];
    logic [31:0] held;
    bit stalled, fin, poked;
    L   = sel ? 4 : 1;
    ncc = (nc > 539) ? 539 : nc;
    occ = (oc > 49) ? 49 : oc;
    for (int o = 0; o < occ; o++) begin
      for (int b = 0; b < ncc; b += L) begin
        msk = 0;
        for (int i = 0; i < L; i++) if (b + i < ncc) msk |= (1 << i);
        exp_q.push_back(pack(b, msk, o, b == 0, b + L >= ncc, (b + L >= ncc) && (o == occ - 1)));
      end
    end

    start = 1'b1;
    nav_count = 11'(nc);
    obs_count = 7'(oc);
    out_ready = 1'b1;
    step();
    start = 1'b0;

    if (exp_q.size() == 0) begin
      chk("zc_done", m_done, 1);
      chk("zc_busy", m_busy, 0);
      chk("zc_valid", m_valid, 0);
      step();
      chk("zc_done_off", m_done, 0);
      chk("zc_valid2", m_valid, 0);
      return;
    end

    chk("st_busy", m_busy, 1);
    chk("st_valid", m_valid, LAT == 1);
    if (LAT == 2) begin
      step();
      chk("st_valid2", m_valid, 1);
    end

    idx = 0; stalled = 0; fin = 0; poked = 0; held = '0;
    for (int guard = 0; guard < 5000 && !fin; guard++) begin
      out_ready = ($urandom_range(99) >= stall);
      if (stalled) begin
        chk("stall_vld", m_valid, 1);
        chk("stall_hold", m_word, held);
      end
      if (m_done) chk("early_done", m_done, 0);
      if (poke_at > 0 && idx == poke_at && !poked) begin
        poked = 1;
        start = 1'b1;
        nav_count = 11'd3;
        obs_count = 7'd1;
      end
      if (m_valid && out_ready) begin
        if (idx < exp_q.size()) chk("beat", m_word, exp_q[idx]);
        else chk("extra_beat", 32'(idx), 32'(exp_q.size()));
        idx++;
        if (idx == exp_q.size()) fin = 1;
        if (abort_at > 0 && idx == abort_at) abort = 1'b1;
      end
      stalled = m_valid && !out_ready;
      held = m_word;
      step();
      start = 1'b0;
      if (abort_at > 0 && idx == abort_at) begin
        abort = 1'b0;
        chk("ab_valid", m_valid, 0);
        chk("ab_done", m_done, 0);
        chk("ab_busy", m_busy, 0);
        return;
      end
    end

    if (!fin) begin
      chk("timeout", 32'(idx), 32'(exp_q.size()));
      return;
    end
    chk("fin_done", m_done, 1);
    chk("fin_valid", m_valid, 0);
    step();
    chk("fin_busy", m_busy, 0);
    chk("fin_done_off", m_done, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    nav_count = '0; obs_count = '0; sel = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = bit'(s);
      #1;
      chk("rst_word", m_word, 0);
      chk("rst_ctl", {29'd0, m_valid, m_busy, m_done}, 0);
    end
    rst_n = 1'b1;
    step();

    sel = 0; cleanup(); run_scan(5, 2, 0, 0, 0);
    sel = 1; cleanup(); run_scan(10, 3, 0, 0, 0);
    sel = 0; cleanup(); run_scan(7, 3, 50, 0, 0);
    sel = 1; cleanup(); run_scan(7, 3, 50, 0, 0);
    sel = 0; cleanup(); run_scan(0, 3, 0, 0, 0);
    sel = 1; cleanup(); run_scan(4, 0, 0, 0, 0);
    sel = 1; cleanup(); run_scan(9, 2, 30, 0, 2);
    sel = 0; cleanup(); run_scan(9, 2, 30, 0, 3);
    sel = 0; cleanup(); run_scan(6, 2, 0, 4, 0);
    run_scan(6, 2, 0, 0, 0);
    sel = 1; cleanup(); run_scan(6, 2, 20, 2, 0);
    run_scan(6, 2, 0, 0, 0);
    sel = 1; cleanup(); run_scan(600, 1, 0, 0, 0);
    sel = 1; cleanup(); run_scan(3, 127, 20, 0, 0);
    sel = 0; cleanup(); run_scan(600, 1, 10, 0, 0);

    // Reset in the middle of a run.
    sel = 1; cleanup();
    start = 1'b1; nav_count = 11'd20; obs_count = 7'd3;
    step();
    start = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    step();
    for (int s = 0; s < 2; s++) begin
      sel = bit'(s);
      #1;
      chk("rstm_word", m_word, 0);
      chk("rstm_ctl", {29'd0, m_valid, m_busy, m_done}, 0);
    end
    rst_n = 1'b1;
    step();
    chk("rstm_after", {30'd0, m_valid, m_done}, 0);
    sel = 0; run_scan(3, 2, 0, 0, 0);

    for (int k = 0; k < 8; k++) begin
      sel = bit'($urandom_range(1));
      cleanup();
      run_scan(int'($urandom_range(40)), int'($urandom_range(5)), int'($urandom_range(60)), 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
